// File: rtl/cmp_iter_pkg.sv
// Shared opcodes, state encodings and result decode for the iterative branch comparator.
// Opcodes follow the RISC-V branch funct3 values; 3'b010 and 3'b011 are illegal.
package cmp_iter_pkg;

    localparam int CMPOP_WIDTH = 3;

    typedef logic [CMPOP_WIDTH-1:0] cmp_op_t;

    localparam cmp_op_t CMP_BEQ  = 3'b000;
    localparam cmp_op_t CMP_BNE  = 3'b001;
    localparam cmp_op_t CMP_BLT  = 3'b100;
    localparam cmp_op_t CMP_BGE  = 3'b101;
    localparam cmp_op_t CMP_BLTU = 3'b110;
    localparam cmp_op_t CMP_BGEU = 3'b111;

    typedef enum logic [1:0] {
        CMPI_IDLE = 2'd0,
        CMPI_RUN  = 2'd1,
        CMPI_DONE = 2'd2
    } cmpi_state_e;

    typedef struct packed {
        logic res;
        logic eq;
        logic lt;
        logic err;
    } cmp_res_t;

    function automatic logic op_is_signed(cmp_op_t op);
        return (op == CMP_BLT) || (op == CMP_BGE);
    endfunction

    // Turns the decided/lt flags of a finished scan into the visible result bits.
    function automatic cmp_res_t cmp_decode(cmp_op_t op, logic decided, logic lt_flag);
        cmp_res_t r;
        r.eq  = !decided;
        r.lt  = decided && lt_flag;
        r.err = 1'b0;
        r.res = 1'b0;
        case (op)
            CMP_BEQ:            r.res = r.eq;
            CMP_BNE:            r.res = !r.eq;
            CMP_BLT, CMP_BLTU:  r.res = r.lt;
            CMP_BGE, CMP_BGEU:  r.res = !r.lt;
            default: begin
                r.res = 1'b0;
                r.eq  = 1'b0;
                r.lt  = 1'b0;
                r.err = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_iter_if.sv
// Request/response bundle for cmp_iter: operand request with valid/ready, result with valid/ready.
// master = operand producer / result consumer, slave = comparator.
interface cmp_iter_if #(
    parameter int WIDTH = 32
);
    import cmp_iter_pkg::*;

    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    cmp_op_t          i_op;
    logic             o_valid;
    logic             i_ready;
    logic             o_res;
    logic             o_eq;
    logic             o_lt;
    logic             o_err;

    modport master (
        output i_flush, i_valid, i_a, i_b, i_op, i_ready,
        input  o_ready, o_valid, o_res, o_eq, o_lt, o_err
    );

    modport slave (
        input  i_flush, i_valid, i_a, i_b, i_op, i_ready,
        output o_ready, o_valid, o_res, o_eq, o_lt, o_err
    );

endinterface

// File: rtl/cmp_iter_chunk.sv
// Unsigned compare of one CHUNK-bit slice; purely combinational.
module cmp_iter_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             lt
);

    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/cmp_iter.sv
// Iterative branch comparator: scans operands CHUNK bits per cycle, MSB chunk first.
// Latency NCHUNK cycles, or fewer with EARLY_EXIT; result held in DONE until i_ready.
module cmp_iter
    import cmp_iter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    cmp_iter_if.slave  bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = $clog2(NCHUNK + 1);

    cmpi_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    cmp_op_t          op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             lt_q, lt_d;
    logic             valid_q, valid_d;
    cmp_res_t         out_q, out_d;

    logic [CHUNK-1:0] ca, cb;
    logic             ch_eq, ch_lt;
    logic             first_diff;
    logic             last_chunk;

    always_comb begin
        ca = '0;
        cb = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IW'(k)) begin
                ca = a_q[k*CHUNK +: CHUNK];
                cb = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    cmp_iter_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a  (ca),
        .b  (cb),
        .eq (ch_eq),
        .lt (ch_lt)
    );

    assign first_diff = !ch_eq && !decided_q;
    assign last_chunk = (idx_q == '0);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        valid_d   = valid_q;
        out_d     = out_q;

        if (bus.i_flush) begin
            state_d = CMPI_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                CMPI_IDLE: begin
                    if (bus.i_valid) begin
                        state_d   = CMPI_RUN;
                        // Flipping both sign bits turns a signed compare into an unsigned one.
                        a_d       = bus.i_a;
                        b_d       = bus.i_b;
                        a_d[WIDTH-1] = bus.i_a[WIDTH-1] ^ op_is_signed(bus.i_op);
                        b_d[WIDTH-1] = bus.i_b[WIDTH-1] ^ op_is_signed(bus.i_op);
                        op_d      = bus.i_op;
                        idx_d     = IW'(NCHUNK - 1);
                        decided_d = 1'b0;
                        lt_d      = 1'b0;
                    end
                end
                CMPI_RUN: begin
                    if (first_diff) begin
                        decided_d = 1'b1;
                        lt_d      = ch_lt;
                    end
                    if (last_chunk || ((EARLY_EXIT != 0) && first_diff)) begin
                        state_d = CMPI_DONE;
                        valid_d = 1'b1;
                        out_d   = cmp_decode(op_q, decided_d, lt_d);
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end
                CMPI_DONE: begin
                    if (bus.i_ready) begin
                        state_d = CMPI_IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = CMPI_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= CMPI_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            valid_q   <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            valid_q   <= valid_d;
            out_q     <= out_d;
        end
    end

    assign bus.o_ready = (state_q == CMPI_IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_res   = out_q.res;
    assign bus.o_eq    = out_q.eq;
    assign bus.o_lt    = out_q.lt;
    assign bus.o_err   = out_q.err;

endmodule

// File: tb/tb_cmp_iter.sv
// Drives four comparator configurations in lockstep with directed vectors and a random sweep.
module tb_cmp_iter;
    import cmp_iter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        t_flush, t_valid, t_ready;
    logic [31:0] t_a, t_b;
    logic [2:0]  t_op;

    cmp_iter_if #(.WIDTH(32)) if_e1 ();
    cmp_iter_if #(.WIDTH(32)) if_e0 ();
    cmp_iter_if #(.WIDTH(32)) if_w  ();
    cmp_iter_if #(.WIDTH(32)) if_n  ();

    assign if_e1.i_flush = t_flush; assign if_e0.i_flush = t_flush;
    assign if_w.i_flush  = t_flush; assign if_n.i_flush  = t_flush;
    assign if_e1.i_valid = t_valid; assign if_e0.i_valid = t_valid;
    assign if_w.i_valid  = t_valid; assign if_n.i_valid  = t_valid;
    assign if_e1.i_ready = t_ready; assign if_e0.i_ready = t_ready;
    assign if_w.i_ready  = t_ready; assign if_n.i_ready  = t_ready;
    assign if_e1.i_a = t_a; assign if_e0.i_a = t_a; assign if_w.i_a = t_a; assign if_n.i_a = t_a;
    assign if_e1.i_b = t_b; assign if_e0.i_b = t_b; assign if_w.i_b = t_b; assign if_n.i_b = t_b;
    assign if_e1.i_op = t_op; assign if_e0.i_op = t_op; assign if_w.i_op = t_op; assign if_n.i_op = t_op;

    cmp_iter #(.WIDTH(32), .CHUNK(8),  .EARLY_EXIT(1)) u_e1 (.i_clk(clk), .i_rst(rst), .bus(if_e1.slave));
    cmp_iter #(.WIDTH(32), .CHUNK(8),  .EARLY_EXIT(0)) u_e0 (.i_clk(clk), .i_rst(rst), .bus(if_e0.slave));
    cmp_iter #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(1)) u_w  (.i_clk(clk), .i_rst(rst), .bus(if_w.slave));
    cmp_iter #(.WIDTH(32), .CHUNK(4),  .EARLY_EXIT(1)) u_n  (.i_clk(clk), .i_rst(rst), .bus(if_n.slave));

    logic [3:0] o_vld, o_rdy, o_res, o_eq, o_lt, o_err;
    assign o_vld = {if_n.o_valid, if_w.o_valid, if_e0.o_valid, if_e1.o_valid};
    assign o_rdy = {if_n.o_ready, if_w.o_ready, if_e0.o_ready, if_e1.o_ready};
    assign o_res = {if_n.o_res,   if_w.o_res,   if_e0.o_res,   if_e1.o_res};
    assign o_eq  = {if_n.o_eq,    if_w.o_eq,    if_e0.o_eq,    if_e1.o_eq};
    assign o_lt  = {if_n.o_lt,    if_w.o_lt,    if_e0.o_lt,    if_e1.o_lt};
    assign o_err = {if_n.o_err,   if_w.o_err,   if_e0.o_err,   if_e1.o_err};

    int cfg_chunk [4] = '{8, 8, 32, 4};
    int cfg_ee    [4] = '{1, 0, 1, 1};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h at %0t", tag, d, got, exp, $time);
        end
    endtask

    // Reference model: cycles from accept to o_valid for a given chunking.
    function automatic int exp_lat(int c, int ee, logic [31:0] a, logic [31:0] b);
        int n = 32 / c;
        logic [31:0] mask = (c == 32) ? 32'hFFFF_FFFF : ((32'h1 << c) - 32'h1);
        if (ee == 0) return n;
        for (int i = n - 1; i >= 0; i--)
            if ((((a ^ b) >> (i * c)) & mask) != 32'h0) return n - i;
        return n;
    endfunction

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic r, output logic e, output logic l, output logic er);
        logic signed_op = (op == 3'b100) || (op == 3'b101);
        logic legal = (op == 3'b000) || (op == 3'b001) || (op[2] == 1'b1);
        e  = (a == b);
        l  = signed_op ? ($signed(a) < $signed(b)) : (a < b);
        er = 1'b0;
        case (op)
            3'b000:         r = e;
            3'b001:         r = !e;
            3'b100, 3'b110: r = l;
            default:        r = !l;
        endcase
        if (!legal) begin
            r = 1'b0; e = 1'b0; l = 1'b0; er = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic r, input logic e, input logic l, input logic er, input int lat_e1);
        int lat [4];
        int want;
        t_op = op; t_a = a; t_b = b; t_valid = 1'b1;
        for (int d = 0; d < 4; d++) begin
            chk("rdy_idle", d, 32'(o_rdy[d]), 32'h1);
            lat[d] = 0;
        end
        tick();
        t_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            for (int d = 0; d < 4; d++)
                if (lat[d] == 0 && o_vld[d]) lat[d] = c;
        end
        for (int d = 0; d < 4; d++) begin
            want = (d == 0) ? lat_e1 : exp_lat(cfg_chunk[d], cfg_ee[d], a, b);
            chk("latency", d, 32'(lat[d]), 32'(want));
            chk("res", d, 32'(o_res[d]), 32'(r));
            chk("eq",  d, 32'(o_eq[d]),  32'(e));
            chk("lt",  d, 32'(o_lt[d]),  32'(l));
            chk("err", d, 32'(o_err[d]), 32'(er));
            chk("rdy_busy", d, 32'(o_rdy[d]), 32'h0);
        end
        t_ready = 1'b1;
        tick();
        t_ready = 1'b0;
        for (int d = 0; d < 4; d++) begin
            chk("vld_drop", d, 32'(o_vld[d]), 32'h0);
            chk("rdy_back", d, 32'(o_rdy[d]), 32'h1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < 4; d++) begin
            chk({tag, "_rdy"}, d, 32'(o_rdy[d]), 32'h1);
            chk({tag, "_vld"}, d, 32'(o_vld[d]), 32'h0);
            chk({tag, "_out"}, d, {28'h0, o_res[d], o_eq[d], o_lt[d], o_err[d]}, 32'h0);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        r, e, l, er;
        int          lat;
    } vec_t;

    // Hand-derived expectations; lat is for CHUNK=8 with early exit.
    vec_t vecs [11] = '{
        '{3'b000, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0, 4},
        '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0, 1},
        '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1},
        '{3'b111, 32'h0000_0100, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b0, 3},
        '{3'b001, 32'h8000_0000, 32'h8000_0001, 1'b1, 1'b0, 1'b1, 1'b0, 4},
        '{3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1},
        '{3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1},
        '{3'b010, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b1, 4},
        '{3'b101, 32'hAAAA_5555, 32'hAAAA_5555, 1'b1, 1'b1, 1'b0, 1'b0, 4},
        '{3'b001, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 4},
        '{3'b110, 32'h0001_0000, 32'h0002_0000, 1'b1, 1'b0, 1'b1, 1'b0, 2}
    };

    logic [2:0] rops [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b011};

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        r, e, l, er;

        rst = 1'b1; t_flush = 1'b0; t_valid = 1'b0; t_ready = 1'b0;
        t_a = '0; t_b = '0; t_op = '0;
        #1;
        check_reset_vals("reset");
        #22;
        rst = 1'b0;
        tick();

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e, vecs[i].l, vecs[i].er, vecs[i].lat);

        // Result held under backpressure while a competing request waits.
        t_op = 3'b100; t_a = 32'hFFFF_FFFF; t_b = 32'h1; t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        repeat (8) tick();
        t_op = 3'b000; t_a = 32'h5; t_b = 32'h5; t_valid = 1'b1;
        repeat (5) begin
            tick();
            for (int d = 0; d < 4; d++) begin
                chk("bp_vld", d, 32'(o_vld[d]), 32'h1);
                chk("bp_res", d, 32'(o_res[d]), 32'h1);
                chk("bp_rdy", d, 32'(o_rdy[d]), 32'h0);
            end
        end
        t_valid = 1'b0; t_ready = 1'b1;
        tick();
        t_ready = 1'b0;
        for (int d = 0; d < 4; d++) chk("bp_release", d, 32'(o_vld[d]), 32'h0);

        // Flush in the second cycle of an op.
        t_op = 3'b001; t_a = 32'h8000_0000; t_b = 32'h8000_0001; t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        tick();
        t_flush = 1'b1;
        tick();
        t_flush = 1'b0;
        for (int d = 0; d < 4; d++) begin
            chk("flush_rdy", d, 32'(o_rdy[d]), 32'h1);
            chk("flush_res_kept", d, 32'(o_res[d]), 32'h1);
            chk("flush_lt_kept", d, 32'(o_lt[d]), 32'h1);
        end
        repeat (6) begin
            tick();
            for (int d = 0; d < 4; d++) chk("flush_no_vld", d, 32'(o_vld[d]), 32'h0);
        end

        // Flush on the same edge as an accept drops the request.
        t_op = 3'b000; t_a = 32'h1; t_b = 32'h1; t_valid = 1'b1; t_flush = 1'b1;
        tick();
        t_valid = 1'b0; t_flush = 1'b0;
        repeat (5) begin
            tick();
            for (int d = 0; d < 4; d++) begin
                chk("flacc_rdy", d, 32'(o_rdy[d]), 32'h1);
                chk("flacc_vld", d, 32'(o_vld[d]), 32'h0);
            end
        end

        // Async reset mid-RUN.
        t_op = 3'b000; t_a = 32'h77; t_b = 32'h77; t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        #2;
        rst = 1'b0;
        tick();

        for (int n = 0; n < 200; n++) begin
            op = rops[$urandom_range(0, 6)];
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = $urandom;
                2:       b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = a ^ (32'h1 << $urandom_range(0, 7));
            endcase
            model(op, a, b, r, e, l, er);
            run_op(op, a, b, r, e, l, er, exp_lat(8, 1, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
